// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues word fetches to instruction
// memory over a req/ack handshake and feeds the IF/ID pipeline register.
// A one-entry hold buffer absorbs a returning fetch while decode stalls.
// Redirects from execute flush wrong-path work. An in-flight request is
// finished off in DROP so that its data can be thrown away safely.
// Optional feature macro: FETCH_MISALIGN_EN. When it is defined, a redirect
// to a non-word-aligned target raises if_id_misalign and issues no fetch.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_id_valid,
   output logic [31:0] if_id_inst,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_pc4,
   output logic        if_id_misalign
);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      HOLD,
      DROP
`ifdef FETCH_MISALIGN_EN
      ,
      MISAL
`endif
   } state_t;

   state_t      state, state_n;
   logic [31:0] pc, pc_n;
   logic [31:0] req_addr, req_addr_n;
   logic [31:0] hold_inst, hold_inst_n;
   logic [31:0] hold_pc, hold_pc_n;
   logic        valid_n;
   logic [31:0] inst_n, ifpc_n, ifpc4_n;
   logic        slot_free;
   logic        launch;
   logic [31:0] launch_addr;

   // A memory request is outstanding in FETCH, and in DROP while the
   // wrong-path request is drained.
   assign imem_req  = (state == FETCH) || (state == DROP);
   assign imem_addr = req_addr;

   // Decode can take a new instruction when IF/ID is empty or not stalled.
   assign slot_free = !if_id_valid || !stall;

   // Any new fetch goes to the redirect target when one is present.
   // Otherwise it goes to the saved PC.
   assign launch_addr = redirect_valid ? redirect_pc : pc;

`ifdef FETCH_MISALIGN_EN
   logic misal, misal_n;
   assign if_id_misalign = misal;
`else
   assign if_id_misalign = 1'b0;
`endif

   // Next-state logic: FSM transitions, PC/request address, hold buffer and IF/ID.
   always_comb begin
      state_n     = state;
      pc_n        = pc;
      req_addr_n  = req_addr;
      hold_inst_n = hold_inst;
      hold_pc_n   = hold_pc;
      valid_n     = if_id_valid;
      inst_n      = if_id_inst;
      ifpc_n      = if_id_pc;
      ifpc4_n     = if_id_pc4;
      launch      = 1'b0;
`ifdef FETCH_MISALIGN_EN
      misal_n     = misal;
`endif

      if (!(stall && if_id_valid)) begin
         valid_n = 1'b0;
         inst_n  = NOP_INST;
      end

      case (state)
         IDLE: begin
            launch = 1'b1;
         end
         FETCH: begin
            if (redirect_valid) begin
               if (imem_ack) begin
                  launch = 1'b1;
               end else begin
                  state_n = DROP;
               end
            end else if (imem_ack) begin
               pc_n = req_addr + 32'd4;
               if (slot_free) begin
                  valid_n    = 1'b1;
                  inst_n     = imem_rdata;
                  ifpc_n     = req_addr;
                  ifpc4_n    = req_addr + 32'd4;
                  req_addr_n = req_addr + 32'd4;
               end else begin
                  hold_inst_n = imem_rdata;
                  hold_pc_n   = req_addr;
                  state_n     = HOLD;
               end
            end
         end
         HOLD: begin
            if (redirect_valid) begin
               launch = 1'b1;
            end else if (!stall) begin
               valid_n = 1'b1;
               inst_n  = hold_inst;
               ifpc_n  = hold_pc;
               ifpc4_n = hold_pc + 32'd4;
               launch  = 1'b1;
            end
         end
         DROP: begin
            if (imem_ack) begin
               launch = 1'b1;
            end
         end
`ifdef FETCH_MISALIGN_EN
         MISAL: begin
            if (redirect_valid) begin
               launch = 1'b1;
            end
         end
`endif
         default: begin
            state_n = IDLE;
         end
      endcase

      if (redirect_valid) begin
         valid_n = 1'b0;
         inst_n  = NOP_INST;
         pc_n    = redirect_pc;
`ifdef FETCH_MISALIGN_EN
         misal_n = 1'b0;
`endif
      end

`ifdef FETCH_MISALIGN_EN
      if (launch && (launch_addr[1:0] != 2'b00)) begin
         state_n = MISAL;
         pc_n    = launch_addr;
         valid_n = 1'b1;
         misal_n = 1'b1;
         inst_n  = NOP_INST;
         ifpc_n  = launch_addr;
         ifpc4_n = launch_addr + 32'd4;
      end else if (launch) begin
         state_n    = FETCH;
         req_addr_n = launch_addr;
      end
`else
      if (launch) begin
         state_n    = FETCH;
         req_addr_n = launch_addr;
      end
`endif
   end

   // State register with synchronous reset for the FSM, PC, hold buffer and IF/ID.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         req_addr    <= RESET_PC;
         hold_inst   <= NOP_INST;
         hold_pc     <= 32'd0;
         if_id_valid <= 1'b0;
         if_id_inst  <= NOP_INST;
         if_id_pc    <= 32'd0;
         if_id_pc4   <= 32'd0;
`ifdef FETCH_MISALIGN_EN
         misal       <= 1'b0;
`endif
      end else begin
         state       <= state_n;
         pc          <= pc_n;
         req_addr    <= req_addr_n;
         hold_inst   <= hold_inst_n;
         hold_pc     <= hold_pc_n;
         if_id_valid <= valid_n;
         if_id_inst  <= inst_n;
         if_id_pc    <= ifpc_n;
         if_id_pc4   <= ifpc4_n;
`ifdef FETCH_MISALIGN_EN
         misal       <= misal_n;
`endif
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage with RESET_PC=0x100.
// It uses a behavioural instruction memory with a programmable number of wait states.
module tb_fetch_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_0100;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_id_valid;
   logic [31:0] if_id_inst;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_pc4;
   logic        if_id_misalign;

   int tests = 0;
   int fails = 0;
   int waits = 0;

   fetch_stage #(
      .RESET_PC(RESET_PC),
      .NOP_INST(NOP)
   ) dut (
      .clk(clk),
      .rst(rst),
      .imem_req(imem_req),
      .imem_addr(imem_addr),
      .imem_ack(imem_ack),
      .imem_rdata(imem_rdata),
      .stall(stall),
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc),
      .if_id_valid(if_id_valid),
      .if_id_inst(if_id_inst),
      .if_id_pc(if_id_pc),
      .if_id_pc4(if_id_pc4),
      .if_id_misalign(if_id_misalign)
   );

   // Memory contents: a fixed scramble of the word address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h0000_0013;
   endfunction

   // Free-running clock with a 10 ns period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory responder: acks a request after 'waits' extra cycles.
   initial begin
      int cnt;
      cnt        = 0;
      imem_ack   = 1'b0;
      imem_rdata = 32'd0;
      forever begin
         @(posedge clk);
         #2;
         if (rst || !imem_req) begin
            cnt      = 0;
            imem_ack = 1'b0;
         end else if (cnt == waits) begin
            cnt        = 0;
            imem_ack   = 1'b1;
            imem_rdata = mem_word(imem_addr);
         end else begin
            cnt      = cnt + 1;
            imem_ack = 1'b0;
         end
      end
   end

   // Hard stop in case the sequence ever wedges.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic r, input logic s, input logic rv,
                                input logic [31:0] rp);
      rst            = r;
      stall          = s;
      redirect_valid = rv;
      redirect_pc    = rp;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] got,
                              input logic [31:0] exp);
      tests++;
      assert (got === exp)
      else begin
         fails++;
         $error("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic waitValid(input int budget);
      int n;
      n = 0;
      while (!if_id_valid && n < budget) begin
         tick();
         n++;
      end
      checkOutput("wait_valid_timeout", {31'd0, if_id_valid}, 32'd1);
   endtask

   // Directed sequence: reset, streaming, stall/hold, a redirect with a 2-wait memory,
   // a redirect combined with a stall, PC wraparound, and a second reset.
   initial begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
      waits = 0;
      repeat (3) tick();
      checkOutput("rst_req",      {31'd0, imem_req}, 32'd0);
      checkOutput("rst_addr",     imem_addr, RESET_PC);
      checkOutput("rst_valid",    {31'd0, if_id_valid}, 32'd0);
      checkOutput("rst_inst",     if_id_inst, NOP);
      checkOutput("rst_pc",       if_id_pc, 32'd0);
      checkOutput("rst_pc4",      if_id_pc4, 32'd0);
      checkOutput("rst_misalign", {31'd0, if_id_misalign}, 32'd0);

      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
      tick();
      checkOutput("start_req",   {31'd0, imem_req}, 32'd1);
      checkOutput("start_addr",  imem_addr, 32'h100);
      checkOutput("start_valid", {31'd0, if_id_valid}, 32'd0);

      tick();
      checkOutput("s0_valid", {31'd0, if_id_valid}, 32'd1);
      checkOutput("s0_pc",    if_id_pc, 32'h100);
      checkOutput("s0_pc4",   if_id_pc4, 32'h104);
      checkOutput("s0_inst",  if_id_inst, mem_word(32'h100));
      checkOutput("s0_addr",  imem_addr, 32'h104);
      tick();
      checkOutput("s1_pc",    if_id_pc, 32'h104);
      checkOutput("s1_pc4",   if_id_pc4, 32'h108);
      checkOutput("s1_inst",  if_id_inst, mem_word(32'h104));
      tick();
      checkOutput("s2_pc",    if_id_pc, 32'h108);
      checkOutput("s2_pc4",   if_id_pc4, 32'h10C);
      checkOutput("s2_addr",  imem_addr, 32'h10C);

      applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
      tick();
      checkOutput("hold_req",   {31'd0, imem_req}, 32'd0);
      checkOutput("hold_pc",    if_id_pc, 32'h108);
      checkOutput("hold_inst",  if_id_inst, mem_word(32'h108));
      checkOutput("hold_valid", {31'd0, if_id_valid}, 32'd1);
      tick();
      tick();
      checkOutput("hold3_pc",   if_id_pc, 32'h108);
      checkOutput("hold3_req",  {31'd0, imem_req}, 32'd0);

      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
      tick();
      checkOutput("unhold_pc",   if_id_pc, 32'h10C);
      checkOutput("unhold_inst", if_id_inst, mem_word(32'h10C));
      checkOutput("unhold_req",  {31'd0, imem_req}, 32'd1);
      checkOutput("unhold_addr", imem_addr, 32'h110);
      tick();
      checkOutput("resume_pc",   if_id_pc, 32'h110);
      checkOutput("resume_addr", imem_addr, 32'h114);

      waits = 2;
      tick();
      checkOutput("w2_valid", {31'd0, if_id_valid}, 32'd0);
      checkOutput("w2_inst",  if_id_inst, NOP);
      checkOutput("w2_addr",  imem_addr, 32'h114);
      tick();
      tick();
      checkOutput("w2_pc",     if_id_pc, 32'h114);
      checkOutput("w2_valid1", {31'd0, if_id_valid}, 32'd1);
      checkOutput("w2_addr1",  imem_addr, 32'h118);

      applyStimulus(1'b0, 1'b0, 1'b1, 32'h200);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
      checkOutput("drop_valid", {31'd0, if_id_valid}, 32'd0);
      checkOutput("drop_inst",  if_id_inst, NOP);
      checkOutput("drop_req",   {31'd0, imem_req}, 32'd1);
      checkOutput("drop_addr",  imem_addr, 32'h118);
      tick();
      checkOutput("drop_addr2", imem_addr, 32'h118);
      tick();
      checkOutput("refetch_addr",  imem_addr, 32'h200);
      checkOutput("refetch_valid", {31'd0, if_id_valid}, 32'd0);
      waitValid(10);
      checkOutput("redir_pc",   if_id_pc, 32'h200);
      checkOutput("redir_inst", if_id_inst, mem_word(32'h200));

      waits = 0;
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h300);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
      checkOutput("rs_valid", {31'd0, if_id_valid}, 32'd0);
      checkOutput("rs_inst",  if_id_inst, NOP);
      checkOutput("rs_addr",  imem_addr, 32'h300);
      checkOutput("rs_req",   {31'd0, imem_req}, 32'd1);
      tick();
      checkOutput("rs_pc",    if_id_pc, 32'h300);
      checkOutput("rs_pc4",   if_id_pc4, 32'h304);
      checkOutput("rs_inst2", if_id_inst, mem_word(32'h300));

      applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
      checkOutput("wrap_valid", {31'd0, if_id_valid}, 32'd0);
      checkOutput("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
      tick();
      checkOutput("wrap_pc",   if_id_pc, 32'hFFFF_FFFC);
      checkOutput("wrap_pc4",  if_id_pc4, 32'h0000_0000);
      checkOutput("wrap_addr", imem_addr, 32'h0000_0000);
      checkOutput("wrap_inst", if_id_inst, mem_word(32'hFFFF_FFFC));
      tick();
      checkOutput("wrap_next_pc",  if_id_pc, 32'h0000_0000);
      checkOutput("wrap_next_pc4", if_id_pc4, 32'h0000_0004);
      checkOutput("misalign_off",  {31'd0, if_id_misalign}, 32'd0);

      applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
      tick();
      checkOutput("rst2_valid", {31'd0, if_id_valid}, 32'd0);
      checkOutput("rst2_req",   {31'd0, imem_req}, 32'd0);
      checkOutput("rst2_addr",  imem_addr, RESET_PC);
      checkOutput("rst2_pc",    if_id_pc, 32'd0);
      checkOutput("rst2_inst",  if_id_inst, NOP);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
